// File: rtl/axi_test_pkg.sv
// Shared state encoding, AXI constants and length legality for the burst memory tester.
package axi_test_pkg;

  typedef enum logic [2:0] {IDLE, AW, W, AR, R, DONE} state_t;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [2:0] SIZE_16    = 3'b001;
  localparam logic [1:0] STRB_ALL   = 2'b11;

  // Only the burst lengths the SDRAM responder supports are exercised.
  function automatic bit legal_len(input logic [7:0] l);
    return (l == 8'd0) || (l == 8'd1) || (l == 8'd3) || (l == 8'd7) || (l == 8'd255);
  endfunction

endpackage

// File: rtl/axi_pattern_chk.sv
// Beat counter plus incrementing-pattern generator; the same pattern drives write data and read compare.
module axi_pattern_chk
  import axi_test_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clr_all,
  input  logic        clr_beat,
  input  logic        adv,
  input  logic        cmp,
  input  logic [15:0] seed,
  input  logic [21:0] base,
  input  logic [15:0] rdata,
  output logic [8:0]  beat,
  output logic [15:0] exp_data,
  output logic [8:0]  err_count,
  output logic [21:0] err_addr
);

  logic [8:0]  beat_q, beat_d;
  logic [8:0]  err_count_q, err_count_d;
  logic [21:0] err_addr_q, err_addr_d;
  logic        mismatch;

  always_comb begin
    exp_data    = seed + {7'd0, beat_q};
    mismatch    = cmp && (rdata != exp_data);
    beat_d      = beat_q;
    err_count_d = err_count_q;
    err_addr_d  = err_addr_q;
    if (mismatch) begin
      if (err_count_q == 9'd0) err_addr_d = base + {13'd0, beat_q};
      if (err_count_q != 9'h100) err_count_d = err_count_q + 9'd1;
    end
    if (adv) beat_d = beat_q + 9'd1;
    if (clr_beat) beat_d = '0;
    if (clr_all) begin
      beat_d      = '0;
      err_count_d = '0;
      err_addr_d  = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      beat_q      <= '0;
      err_count_q <= '0;
      err_addr_q  <= '0;
    end else begin
      beat_q      <= beat_d;
      err_count_q <= err_count_d;
      err_addr_q  <= err_addr_d;
    end
  end

  assign beat      = beat_q;
  assign err_count = err_count_q;
  assign err_addr  = err_addr_q;

endmodule

// File: rtl/axi_burst_master.sv
// AXI initiator: writes one incrementing-pattern burst, reads it back and reports the comparison.
module axi_burst_master
  import axi_test_pkg::*;
#(
  parameter logic [7:0] ID             = 8'h01,
  parameter int         TIMEOUT_CYCLES = 65535
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [21:0] base_addr,
  input  logic [7:0]  len,
  input  logic [15:0] seed,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        len_err,
  output logic        timeout,
  output logic [8:0]  err_count,
  output logic [21:0] err_addr,
  output logic [7:0]  axi_awid,
  output logic [21:0] axi_awaddr,
  output logic [7:0]  axi_awlen,
  output logic [2:0]  axi_awsize,
  output logic [1:0]  axi_awburst,
  output logic        axi_awvalid,
  input  logic        axi_awready,
  output logic [15:0] axi_wdata,
  output logic [1:0]  axi_wstrb,
  output logic        axi_wvalid,
  output logic        axi_wlast,
  input  logic        axi_wready,
  input  logic [7:0]  axi_bid,
  input  logic        axi_bvalid,
  output logic        axi_bready,
  output logic [7:0]  axi_arid,
  output logic [21:0] axi_araddr,
  output logic [7:0]  axi_arlen,
  output logic [2:0]  axi_arsize,
  output logic [1:0]  axi_arburst,
  output logic        axi_arvalid,
  input  logic        axi_arready,
  input  logic [7:0]  axi_rid,
  input  logic [15:0] axi_rdata,
  input  logic        axi_rlast,
  input  logic        axi_rvalid,
  output logic        axi_rready
);

  localparam int                WAIT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

  state_t              state_q, state_d;
  logic [21:0]         base_q, base_d;
  logic [7:0]          len_q, len_d;
  logic [15:0]         seed_q, seed_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic                busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  logic                len_err_q, len_err_d, timeout_q, timeout_d;
  logic                awvalid_q, awvalid_d, wvalid_q, wvalid_d;
  logic                arvalid_q, arvalid_d, rready_q, rready_d;
  logic                clr_all, clr_beat, adv, cmp, abort, last_beat, wait_expired;
  logic [8:0]          beat;
  logic [15:0]         exp_data;
  logic                unused_inputs;

  axi_pattern_chk u_chk (
    .clk      (clk),
    .reset    (reset),
    .clr_all  (clr_all),
    .clr_beat (clr_beat),
    .adv      (adv),
    .cmp      (cmp),
    .seed     (seed_q),
    .base     (base_q),
    .rdata    (axi_rdata),
    .beat     (beat),
    .exp_data (exp_data),
    .err_count(err_count),
    .err_addr (err_addr)
  );

  assign last_beat    = (beat == {1'b0, len_q});
  assign wait_expired = (wait_q == WAIT_LAST);

  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    len_d     = len_q;
    seed_d    = seed_q;
    wait_d    = wait_q + WAIT_W'(1);
    busy_d    = busy_q;
    done_d    = 1'b0;
    pass_d    = pass_q;
    len_err_d = len_err_q;
    timeout_d = timeout_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    arvalid_d = arvalid_q;
    rready_d  = rready_q;
    clr_all   = 1'b0;
    clr_beat  = 1'b0;
    adv       = 1'b0;
    cmp       = 1'b0;
    abort     = 1'b0;
    case (state_q)
      IDLE: begin
        wait_d = '0;
        if (start) begin
          base_d    = base_addr;
          len_d     = len;
          seed_d    = seed;
          clr_all   = 1'b1;
          busy_d    = 1'b1;
          pass_d    = 1'b0;
          timeout_d = 1'b0;
          len_err_d = !legal_len(len);
          if (legal_len(len)) begin
            awvalid_d = 1'b1;
            state_d   = AW;
          end else begin
            state_d = DONE;
          end
        end
      end
      AW: begin
        if (axi_awready) begin
          awvalid_d = 1'b0;
          wvalid_d  = 1'b1;
          wait_d    = '0;
          state_d   = W;
        end else if (wait_expired) begin
          abort = 1'b1;
        end
      end
      W: begin
        if (axi_wready) begin
          adv    = 1'b1;
          wait_d = '0;
          if (last_beat) begin
            wvalid_d  = 1'b0;
            arvalid_d = 1'b1;
            clr_beat  = 1'b1;
            state_d   = AR;
          end
        end else if (wait_expired) begin
          abort = 1'b1;
        end
      end
      AR: begin
        if (axi_arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          wait_d    = '0;
          state_d   = R;
        end else if (wait_expired) begin
          abort = 1'b1;
        end
      end
      R: begin
        // The responder ignores back-pressure, so every rvalid cycle is a beat.
        if (axi_rvalid) begin
          adv    = 1'b1;
          cmp    = 1'b1;
          wait_d = '0;
          if (last_beat) begin
            rready_d = 1'b0;
            state_d  = DONE;
          end
        end else if (wait_expired) begin
          abort = 1'b1;
        end
      end
      DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        pass_d  = (err_count == 9'd0) && !timeout_q && !len_err_q;
        wait_d  = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (abort) begin
      awvalid_d = 1'b0;
      wvalid_d  = 1'b0;
      arvalid_d = 1'b0;
      rready_d  = 1'b0;
      timeout_d = 1'b1;
      wait_d    = '0;
      state_d   = DONE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      base_q    <= '0;
      len_q     <= '0;
      seed_q    <= '0;
      wait_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      len_err_q <= 1'b0;
      timeout_q <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      len_q     <= len_d;
      seed_q    <= seed_d;
      wait_q    <= wait_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
      len_err_q <= len_err_d;
      timeout_q <= timeout_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign pass        = pass_q;
  assign len_err     = len_err_q;
  assign timeout     = timeout_q;
  assign axi_awid    = ID;
  assign axi_awaddr  = base_q;
  assign axi_awlen   = len_q;
  assign axi_awsize  = SIZE_16;
  assign axi_awburst = BURST_INCR;
  assign axi_awvalid = awvalid_q;
  assign axi_wdata   = exp_data;
  assign axi_wstrb   = STRB_ALL;
  assign axi_wvalid  = wvalid_q;
  assign axi_wlast   = wvalid_q && last_beat;
  assign axi_bready  = 1'b1;
  assign axi_arid    = ID;
  assign axi_araddr  = base_q;
  assign axi_arlen   = len_q;
  assign axi_arsize  = SIZE_16;
  assign axi_arburst = BURST_INCR;
  assign axi_arvalid = arvalid_q;
  assign axi_rready  = rready_q;

  // Write responses, read IDs and rlast carry nothing this tester needs.
  assign unused_inputs = ^{axi_bid, axi_bvalid, axi_rid, axi_rlast};

endmodule

// File: doc/axi_burst_master.md
Name: axi_burst_master

Overview:
- AXI initiator that drives the SDRAM controller's AXI responder port (same 16-bit data, 22-bit word-address subset) for memory test traffic.
- On a start pulse it writes one incrementing-pattern burst, reads the same burst back and compares beat by beat.
- Reports pass/fail, error count, first failing address and timeouts to a host/test harness.

Parameters:
- ID, 8'h01, value driven on awid/arid; rid is not checked.
- TIMEOUT_CYCLES, 65535, maximum cycles allowed in any wait state before aborting.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous active-high reset
- start  in  1  one-cycle request; sampled only in IDLE
- base_addr  in  22  burst start address {bank[21:20], row[19:8], col[7:0]}
- len  in  8  AXI length; legal values 0,1,3,7,255
- seed  in  16  first pattern word
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle completion pulse
- pass  out  1  valid at done: no mismatch, no timeout, legal len
- len_err  out  1  valid at done: illegal len
- timeout  out  1  valid at done: wait state exceeded TIMEOUT_CYCLES
- err_count  out  9  mismatching beats in last run
- err_addr  out  22  address of first mismatch
- axi_awid/awaddr/awlen/awsize/awburst/awvalid  out  8/22/8/3/2/1
- axi_awready  in  1
- axi_wdata/wstrb/wvalid/wlast  out  16/2/1/1
- axi_wready  in  1
- axi_bid  in  8; axi_bvalid  in  1; axi_bready  out  1
- axi_arid/araddr/arlen/arsize/arburst/arvalid  out  8/22/8/3/2/1
- axi_arready  in  1
- axi_rid  in  8; axi_rdata  in  16; axi_rlast  in  1; axi_rvalid  in  1; axi_rready  out  1

Behaviour:
- Reset state: all valids 0, bready=1, rready=0, busy/done/pass/len_err/timeout 0, err_count 0, err_addr 0, state IDLE.
- Constant drives: awsize=arsize=3'b001, awburst=arburst=2'b01 (INCR), wstrb=2'b11.
- IDLE, start=1:
  - Latch base_addr, len and seed; clear all result registers; set busy.
  - Legal len: go to AW.
  - Illegal len: go to DONE next cycle with len_err=1 and no bus activity.
- AW:
  - awvalid=1, awaddr=base, awlen=len.
  - On awvalid&awready: drop awvalid, go to W.
- W:
  - wvalid=1, wdata=seed+beat (16-bit wrap).
  - Beat advances on wvalid&wready; wlast=1 only on beat==len.
  - After the last beat: wvalid=0, go to AR.
  - bvalid is not awaited. bready stays 1; any bvalid is ignored.
- AR:
  - arvalid=1, araddr=base, arlen=len.
  - On arvalid&arready: drop arvalid, go to R.
- R:
  - rready=1 for the whole state; the responder does not honour back-pressure.
  - Each rvalid cycle is one beat. Compare rdata against seed+beat.
  - On mismatch, increment err_count. If it is the first mismatch, err_addr=base+beat (22-bit wrap).
  - After beat len: rready=0, go to DONE. rlast is not required.
- DONE: one-cycle done pulse; pass=(err_count==0)&!timeout&!len_err; busy=0; return to IDLE. Results hold until the next start.
- Timeout:
  - A wait counter clears on each state entry and on each handshake; it increments otherwise.
  - Reaching TIMEOUT_CYCLES in AW/W/AR/R: drop all valids/rready, set timeout, go to DONE.
- Beat counter is 9 bits, so 256 beats for len=255. err_count saturates at 256.
- start while busy is ignored.
- Reset mid-operation aborts immediately to reset values; no partial burst is resumed.

Decomposition:
- Package axi_test_pkg:
  - state enum {IDLE, AW, W, AR, R, DONE}.
  - INCR burst and size-16 constants.
  - Function legal_len(len) returning bit.
- Sub-module axi_pattern_chk:
  - Contains the beat counter, expected-data generator, comparator, err_count and err_addr.
  - Reused for both write-data generation and read compare.

Test Plan:
- len=0, seed=16'h1234, base=22'h000010, ideal responder -> one W beat 16'h1234 with wlast=1; read returns 16'h1234; done with pass=1, err_count=0.
- len=7, seed=16'hA000 -> W beats 16'hA000..16'hA007, wlast only on 8th; arlen=7; pass=1.
- len=5 -> done within 2 cycles of start, len_err=1, pass=0; awvalid/arvalid never asserted.
- len=3, seed=16'hFFFE, responder returns 16'h0000 on beat 2 -> expected data wraps FFFE,FFFF,0000,0001 so no error; responder then corrupts beat 1 -> err_count=1, err_addr=base+1.
- awready held 0 with TIMEOUT_CYCLES=16 -> after 16 cycles awvalid=0, timeout=1, pass=0, done pulses.
- reset asserted in W after 3 of 8 beats -> all valids 0 same edge (async), busy=0; next start runs a clean full burst.
